ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the single-cycle MIPS core. It sits directly upstream of the controller. It owns the PC, fetches each instruction over a req/ack instruction-memory handshake, and holds the instruction in the IR. It also presents the decoded fields (OP, Funct, etc.) to the controller. On retirement it computes the next PC from the controller's NPCOp/PCWr.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- imem_req  output  1  fetch request; high only in FETCH.
- imem_addr  output  32  byte address of fetch; equals pc.
- imem_ack  input  1  memory has valid imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- NPCOp  input  2  next-PC select from controller: 00 PC+4, 01 branch, 10 jump, 11 register (jr).
- PCWr  input  1  controller requests non-sequential next PC.
- rs_data  input  32  GPR[rs], used for NPCOp=11.
- stall  input  1  hold current instruction in EXEC.
- instr_valid  output  1  IR holds the executing instruction; datapath writes are qualified by this.
- instr  output  32  IR contents.
- OP  output  6  instr[31:26].
- Funct  output  6  instr[5:0].
- Rs, Rt, Rd  output  5 each  instr[25:21], [20:16], [15:11].
- Imm16  output  16  instr[15:0].
- pc  output  32  address of the current instruction.
- pc4  output  32  pc+4 (jal link value).
- err  output  1  sticky misaligned-target flag.

## Operation

- FSM states: IDLE, FETCH, EXEC, HALT. Moore outputs: imem_req=(FETCH), instr_valid=(EXEC).
- Reset (rst_n low, any state, immediately): state=IDLE, pc=RESET_PC, IR=0, err=0. All outputs therefore read imem_req=0, instr_valid=0, instr=0, pc=RESET_PC, pc4=RESET_PC+4, err=0.
- IDLE -> FETCH unconditionally on the first edge after rst_n rises.
- FETCH: imem_addr=pc, held stable until ack.
  - On an edge with imem_ack=1: IR<=imem_rdata, state->EXEC.
  - Otherwise the unit remains in FETCH with IR unchanged.
  - imem_ack outside FETCH is ignored.
- EXEC: IR and pc stable.
  - stall=1: remain in EXEC. instr_valid stays 1 and the controller is re-driven each cycle; the datapath must tolerate repeats.
  - stall=0: pc<=npc, state->FETCH.
- npc, all 32-bit modulo 2^32:
  - PCWr=0 -> pc4, regardless of NPCOp.
  - PCWr=1, NPCOp=00 -> pc4.
  - PCWr=1, NPCOp=01 -> pc4 + {{14{Imm16[15]}},Imm16,2'b00}.
  - PCWr=1, NPCOp=10 -> {pc4[31:28], instr[25:0], 2'b00}.
  - PCWr=1, NPCOp=11 -> rs_data.
- Misalignment: if npc[1:0]!=0 at the retiring edge (only possible via NPCOp=11):
  - pc is not updated; state->HALT; err<=1.
- HALT: imem_req=0, instr_valid=0, pc/IR frozen. Exit only by reset.
- PC wrap at 32'hFFFF_FFFC+4 -> 0, no error.

## Timing

- Zero-wait memory (imem_ack high in the first FETCH cycle): 2 cycles per instruction (FETCH, EXEC).
- N-cycle ack latency: N+1 FETCH cycles + 1 EXEC cycle.
- IR and decoded fields are valid from the cycle after the ack edge and through all of EXEC.
- PCWr, NPCOp and rs_data are sampled only at the retiring edge (EXEC, stall=0). Values at any other time have no effect.
- New pc is visible on imem_addr in the cycle immediately after retirement.
- Reset asserted mid-FETCH or mid-EXEC aborts the transaction. imem_req drops combinationally with the state, and any ack in flight is discarded.
- Simultaneous stall=1 and misaligned npc: no halt until stall drops.

## Test plan

- Reset with RESET_PC=0x3000: all outputs at reset values; imem_req first rises one cycle after rst_n deasserts; imem_addr=0x3000.
- Sequential fetch: acks at latency 0, then 3 cycles; PCWr=0. Expect pc 0x3000 -> 0x3004 -> 0x3008. Each instruction shows exactly 1 instr_valid cycle with the correct OP/Funct.
- Taken beq at 0x3010, Imm16=0xFFFF, PCWr=1, NPCOp=01: next imem_addr=0x3010. With Imm16=0x0002: next imem_addr=0x301C.
- jal at 0x3020, instr[25:0]=0x0000C10, NPCOp=10, PCWr=1: pc4=0x3024 during EXEC; next imem_addr=0x0000_3040.
- jr with rs_data=0x3002: err=1, state HALT, imem_req stays 0, pc holds 0x3xxx. Also jr with rs_data=0x3100: next imem_addr=0x3100, err=0.
- stall held 4 cycles in EXEC: instr_valid high for 5 cycles, pc unchanged. rst_n pulsed low mid-FETCH with ack pending: IR=0, pc=RESET_PC, and refetch starts from 0x3000.

Source files
------------

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module      : ifu
// Description : Instruction fetch unit for the single-cycle MIPS core. Owns
//               the PC, fetches each instruction over a req/ack memory
//               handshake, holds it in the IR, presents the decoded fields to
//               the controller and computes the next PC when an instruction
//               retires.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory handshake
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    // next-PC control from the controller
    input  logic [1:0]  NPCOp,
    input  logic        PCWr,
    input  logic [31:0] rs_data,
    input  logic        stall,
    // instruction presentation
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  Funct,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] Imm16,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [1:0] C_NPC_SEQ    = 2'b00;
    localparam logic [1:0] C_NPC_BRANCH = 2'b01;
    localparam logic [1:0] C_NPC_JUMP   = 2'b10;
    localparam logic [1:0] C_NPC_REG    = 2'b11;

    localparam logic [31:0] C_FOUR = 32'd4;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_err;

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;
    logic        w_retire;
    logic        w_misaligned;
    logic        w_fetch_done;

    // Sequential successor and sign-extended, word-scaled branch offset.
    assign w_pc4    = r_pc + C_FOUR;
    assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

    // Next-PC select; PCWr low forces the sequential path whatever NPCOp says.
    always_comb begin
        w_npc = w_pc4;
        if (PCWr) begin
            case (NPCOp)
                C_NPC_SEQ:    w_npc = w_pc4;
                C_NPC_BRANCH: w_npc = w_pc4 + w_br_off;
                C_NPC_JUMP:   w_npc = {w_pc4[31:28], r_ir[25:0], 2'b00};
                C_NPC_REG:    w_npc = rs_data;
                default:      w_npc = w_pc4;
            endcase
        end
    end

    // Only a register target can be misaligned; all other sources are word-aligned.
    assign w_misaligned = (w_npc[1:0] != 2'b00);
    assign w_retire     = (r_state == S_EXEC) && !stall;
    assign w_fetch_done = (r_state == S_FETCH) && imem_ack;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; HALT is terminal until reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_FETCH;
            S_FETCH: if (imem_ack) w_state_next = S_EXEC;
            S_EXEC:  if (!stall)   w_state_next = w_misaligned ? S_HALT : S_FETCH;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            S_FETCH: imem_req    = 1'b1;
            S_EXEC:  instr_valid = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    // PC, IR and sticky error; a misaligned retirement leaves the PC untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_PC;
            r_ir  <= 32'd0;
            r_err <= 1'b0;
        end else begin
            if (w_fetch_done) begin
                r_ir <= imem_rdata;
            end
            if (w_retire) begin
                if (w_misaligned) begin
                    r_err <= 1'b1;
                end else begin
                    r_pc <= w_npc;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc4       = w_pc4;
    assign err       = r_err;
    assign instr     = r_ir;
    assign OP        = r_ir[31:26];
    assign Rs        = r_ir[25:21];
    assign Rt        = r_ir[20:16];
    assign Rd        = r_ir[15:11];
    assign Imm16     = r_ir[15:0];
    assign Funct     = r_ir[5:0];

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu
// Description : Self-checking bench for ifu. Expected instruction/PC pairs
//               are queued when the memory acknowledges and compared when the
//               unit presents the instruction in EXEC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu;

    localparam logic [31:0] C_RST_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  NPCOp;
    logic        PCWr;
    logic [31:0] rs_data;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  OP;
    logic [5:0]  Funct;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] Imm16;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] iw;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;

    ifu #(.RESET_PC(C_RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .NPCOp       (NPCOp),
        .PCWr        (PCWr),
        .rs_data     (rs_data),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .OP          (OP),
        .Funct       (Funct),
        .Rs          (Rs),
        .Rt          (Rt),
        .Rd          (Rd),
        .Imm16       (Imm16),
        .pc          (pc),
        .pc4         (pc4),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Assert reset, check reset values, release on a falling edge and
    // confirm that the request rises exactly one cycle later.
    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 ||
            pc !== C_RST_PC || pc4 !== C_RST_PC + 32'd4 || err !== 1'b0) begin
            failures++;
            $display("FAIL %s reset_vals: req=%b valid=%b instr=%h pc=%h pc4=%h err=%b expected 0 0 00000000 %h %h 0",
                     name, imem_req, instr_valid, instr, pc, pc4, err, C_RST_PC, C_RST_PC + 32'd4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_req: imem_req=%b expected 0", name, imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== C_RST_PC) begin
            failures++;
            $display("FAIL %s first_fetch: req=%b addr=%h expected 1 %h", name, imem_req, imem_addr, C_RST_PC);
        end
        m_pc = C_RST_PC;
    endtask

    // Run one instruction from FETCH through retirement. Entered and left on
    // a falling edge with the unit in FETCH (or HALT when exp_halt is set).
    task automatic exec_instr(input string name, input logic [31:0] iw, input int lat,
                              input int nstall, input logic pcwr, input logic [1:0] op,
                              input logic [31:0] rs, input logic exp_halt,
                              input logic [31:0] exp_next);
        exp_t e;
        int   vcnt;
        bit   got;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            failures++;
            $display("FAIL %s fetch_addr: req=%b addr=%h expected 1 %h", name, imem_req, imem_addr, m_pc);
        end
        for (int i = 0; i < lat; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s fetch_wait: req=%b addr=%h valid=%b expected 1 %h 0",
                         name, imem_req, imem_addr, instr_valid, m_pc);
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = iw;
        e.pc = m_pc;
        e.iw = iw;
        sb.push_back(e);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            if (instr_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s exec_timeout: instr_valid=%b expected 1 within 4 cycles", name, instr_valid);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        checks++;
        if (instr !== e.iw || pc !== e.pc || pc4 !== e.pc + 32'd4 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s exec_ir: instr=%h pc=%h pc4=%h req=%b expected %h %h %h 0",
                     name, instr, pc, pc4, imem_req, e.iw, e.pc, e.pc + 32'd4);
        end
        checks++;
        if (OP !== e.iw[31:26] || Rs !== e.iw[25:21] || Rt !== e.iw[20:16] ||
            Rd !== e.iw[15:11] || Funct !== e.iw[5:0] || Imm16 !== e.iw[15:0]) begin
            failures++;
            $display("FAIL %s decode: OP=%h Rs=%h Rt=%h Rd=%h Funct=%h Imm16=%h expected %h %h %h %h %h %h",
                     name, OP, Rs, Rt, Rd, Funct, Imm16, e.iw[31:26], e.iw[25:21], e.iw[20:16],
                     e.iw[15:11], e.iw[5:0], e.iw[15:0]);
        end
        vcnt = 1;
        // While stalled, present a misaligned register target: it must not halt.
        for (int i = 0; i < nstall; i++) begin
            stall   = 1'b1;
            PCWr    = 1'b1;
            NPCOp   = 2'b11;
            rs_data = 32'h0000_3002;
            @(negedge clk);
            if (instr_valid === 1'b1) vcnt++;
            checks++;
            if (pc !== e.pc || instr !== e.iw || err !== 1'b0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL %s stall_hold: pc=%h instr=%h err=%b req=%b expected %h %h 0 0",
                         name, pc, instr, err, imem_req, e.pc, e.iw);
            end
        end
        stall   = 1'b0;
        PCWr    = pcwr;
        NPCOp   = op;
        rs_data = rs;
        @(negedge clk);
        PCWr    = $urandom;
        NPCOp   = $urandom;
        rs_data = $urandom;
        checks++;
        if (vcnt != nstall + 1) begin
            failures++;
            $display("FAIL %s valid_cycles: got=%0d expected %0d", name, vcnt, nstall + 1);
        end
        checks++;
        if (exp_halt) begin
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || err !== 1'b1 || pc !== e.pc) begin
                failures++;
                $display("FAIL %s halt: req=%b valid=%b err=%b pc=%h expected 0 0 1 %h",
                         name, imem_req, instr_valid, err, pc, e.pc);
            end
        end else begin
            if (imem_req !== 1'b1 || imem_addr !== exp_next || instr_valid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL %s next_pc: req=%b addr=%h valid=%b err=%b expected 1 %h 0 0",
                         name, imem_req, imem_addr, instr_valid, err, exp_next);
            end
            m_pc = exp_next;
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_sequential();
        exec_instr("seq0", 32'h0123_4820, 0, 0, 1'b0, 2'b10, 32'h0, 1'b0, 32'h0000_3004);
        exec_instr("seq1", 32'h8C43_0004, 3, 0, 1'b0, 2'b11, 32'h1, 1'b0, 32'h0000_3008);
        exec_instr("seq2", 32'h0000_0000, 1, 0, 1'b0, 2'b01, 32'h0, 1'b0, 32'h0000_300C);
        exec_instr("seq3", 32'h3C01_1234, 2, 0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_3010);
    endtask

    task automatic test_branch();
        exec_instr("beq_back", 32'h1022_FFFF, 0, 0, 1'b1, 2'b01, 32'h0, 1'b0, 32'h0000_3010);
        exec_instr("beq_fwd",  32'h1022_0002, 1, 0, 1'b1, 2'b01, 32'h0, 1'b0, 32'h0000_301C);
        exec_instr("pcwr_lo",  32'h1022_0010, 0, 0, 1'b0, 2'b01, 32'h0, 1'b0, 32'h0000_3020);
    endtask

    task automatic test_jal();
        exec_instr("jal", 32'h0C00_0C10, 0, 0, 1'b1, 2'b10, 32'h0, 1'b0, 32'h0000_3040);
    endtask

    task automatic test_stall();
        exec_instr("stall4", 32'h0085_1822, 0, 4, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_3044);
    endtask

    task automatic test_jr_aligned();
        exec_instr("jr_ok", 32'h03E0_0008, 2, 1, 1'b1, 2'b11, 32'h0000_3100, 1'b0, 32'h0000_3100);
    endtask

    // Reset mid-FETCH with an ack pending: the ack is discarded and the
    // unit refetches from the reset vector with a cleared IR.
    task automatic test_reset_mid_fetch();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== C_RST_PC || instr !== 32'd0 || instr_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid async: req=%b pc=%h instr=%h valid=%b err=%b expected 0 %h 00000000 0 0",
                     imem_req, pc, instr, instr_valid, err, C_RST_PC);
        end
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (instr !== 32'd0 || pc !== C_RST_PC) begin
            failures++;
            $display("FAIL rst_mid ack_drop: instr=%h pc=%h expected 00000000 %h", instr, pc, C_RST_PC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== C_RST_PC || instr !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid refetch: req=%b addr=%h instr=%h expected 1 %h 00000000",
                     imem_req, imem_addr, instr, C_RST_PC);
        end
        m_pc = C_RST_PC;
    endtask

    task automatic test_wrap();
        exec_instr("jr_top", 32'h03E0_0008, 0, 0, 1'b1, 2'b11, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
        exec_instr("wrap",   32'h2108_0001, 0, 0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_0000);
    endtask

    // Misaligned jr halts; afterwards acks and control inputs are ignored.
    task automatic test_jr_misaligned();
        exec_instr("jr_bad", 32'h0060_0008, 1, 0, 1'b1, 2'b11, 32'h0000_3002, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            stall      = 1'b0;
            PCWr       = 1'b1;
            NPCOp      = 2'b00;
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== C_RST_PC ||
                instr !== 32'h0060_0008 || err !== 1'b1) begin
                failures++;
                $display("FAIL halt_hold: req=%b valid=%b pc=%h instr=%h err=%b expected 0 0 %h 00600008 1",
                         imem_req, instr_valid, pc, instr, err, C_RST_PC);
            end
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        NPCOp      = 2'b00;
        PCWr       = 1'b0;
        rs_data    = 32'd0;
        stall      = 1'b0;
        m_pc       = C_RST_PC;
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_stall();
        test_jr_aligned();
        test_reset_mid_fetch();
        test_wrap();
        do_reset("reset2");
        test_jr_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
